// File: rtl/rv_fetch_queue.sv
// Instruction fetch queue: issues one word-aligned bus request at a time, buffers
// fetched words and presents decoded 16/32-bit instructions to the decode stage.
module rv_fetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4,
  parameter bit          EXT_C      = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  output logic                   o_cyc,
  output logic [31:0]            o_addr,
  input  logic                   i_ack,
  input  logic [31:0]            i_data,
  output logic                   o_valid,
  output logic [31:0]            o_pc,
  output logic [31:0]            o_instr,
  output logic                   o_compressed,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_TWO  = (AW+1)'(2);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [31:0] PC_MASK  = EXT_C ? ~32'h1 : ~32'h3;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   fetch_q, fetch_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW:0]   level_q, level_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          cyc_q, cyc_d;

  logic [31:0]   head_word, next_word, instr;
  logic [15:0]   head_half;
  logic          offset, is_comp, head_valid;
  logic          push, accept, pop;

  // Head decode: the instruction starts at halfword offset pc[1] of the head word;
  // a 32-bit instruction at offset 1 borrows the low half of the next word.
  assign head_word  = mem_q[rd_ptr_q];
  assign next_word  = mem_q[rd_ptr_q + PTR_ONE];
  assign offset     = EXT_C && pc_q[1];
  assign head_half  = offset ? head_word[31:16] : head_word[15:0];
  assign is_comp    = EXT_C && (head_half[1:0] != 2'b11);
  assign head_valid = (level_q != '0) && (is_comp || !offset || (level_q >= LVL_TWO));

  always_comb begin
    if (is_comp)     instr = {16'h0000, head_half};
    else if (offset) instr = {next_word[15:0], head_word[31:16]};
    else             instr = head_word;
  end

  // Handshakes: a bus word transfers when o_cyc & i_ack; an instruction transfers
  // when o_valid & i_ready. A redirect overrides both in the same cycle.
  assign push   = cyc_q & i_ack & ~i_redirect;
  assign accept = head_valid & i_ready & ~i_redirect;
  assign pop    = accept & (offset | ~is_comp);

  always_comb begin
    fetch_d  = fetch_q;
    pc_d     = pc_q;
    level_d  = level_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cyc_d    = cyc_q;
    if (i_redirect) begin
      fetch_d  = i_redirect_pc & ~32'h3;
      pc_d     = i_redirect_pc & PC_MASK;
      level_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cyc_d    = 1'b1;
    end else begin
      if (push) begin
        fetch_d  = fetch_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (accept) pc_d = pc_q + (is_comp ? 32'd2 : 32'd4);
      level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      // A pending request stays up; a new one is issued only if its word will fit.
      cyc_d   = (cyc_q & ~i_ack) | (level_d < LVL_FULL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      fetch_q  <= RESET_ADDR & ~32'h3;
      pc_q     <= RESET_ADDR & ~32'h1;
      level_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cyc_q    <= 1'b0;
    end else begin
      fetch_q  <= fetch_d;
      pc_q     <= pc_d;
      level_q  <= level_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cyc_q    <= cyc_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_cyc        = cyc_q & i_reset_n & ~i_redirect;
  assign o_addr       = fetch_q;
  assign o_valid      = head_valid & i_reset_n;
  assign o_pc         = pc_q;
  assign o_instr      = instr;
  assign o_compressed = is_comp;
  assign o_level      = i_reset_n ? level_q : '0;

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: a memory image plus an address-level model of the
// instruction stream; a second instance covers EXT_C=0 and address wrap.
module tb_rv_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset_n, a_redirect, a_cyc, a_ack, a_valid, a_comp, a_ready;
  logic [31:0] a_redirect_pc, a_addr, a_data, a_pc, a_instr;
  logic [2:0]  a_level;
  logic        b_reset_n, b_redirect, b_cyc, b_ack, b_valid, b_comp, b_ready;
  logic [31:0] b_redirect_pc, b_addr, b_data, b_pc, b_instr;
  logic [2:0]  b_level;

  rv_fetch_queue #(.RESET_ADDR(32'h0000_0000), .DEPTH(DEPTH), .EXT_C(1'b1)) u_dut (
    .i_clk(clk), .i_reset_n(a_reset_n), .i_redirect(a_redirect), .i_redirect_pc(a_redirect_pc),
    .o_cyc(a_cyc), .o_addr(a_addr), .i_ack(a_ack), .i_data(a_data), .o_valid(a_valid),
    .o_pc(a_pc), .o_instr(a_instr), .o_compressed(a_comp), .i_ready(a_ready), .o_level(a_level));

  rv_fetch_queue #(.RESET_ADDR(32'hFFFF_FFFC), .DEPTH(DEPTH), .EXT_C(1'b0)) u_dut_b (
    .i_clk(clk), .i_reset_n(b_reset_n), .i_redirect(b_redirect), .i_redirect_pc(b_redirect_pc),
    .o_cyc(b_cyc), .o_addr(b_addr), .i_ack(b_ack), .i_data(b_data), .o_valid(b_valid),
    .o_pc(b_pc), .o_instr(b_instr), .o_compressed(b_comp), .i_ready(b_ready), .o_level(b_level));

  int checks = 0;
  int errors = 0;
  logic [31:0] seed;
  logic [31:0] img [logic [31:0]];

  // Reference model state: next instruction address and next word address to fetch.
  logic [31:0] m_pc, m_fetch;
  logic        m_fresh;
  logic        obs_cyc, obs_valid, obs_comp;
  logic [31:0] obs_addr, obs_pc, obs_instr, obs_level;
  logic        e_cyc, e_valid, e_comp;
  logic [31:0] e_addr, e_pc, e_instr, e_level;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (img.exists(w)) return img[w];
    return (w * 32'h9E37_79B1) ^ (w >> 5) ^ seed;
  endfunction

  function automatic logic [15:0] mem16(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic int unsigned ilen(input logic [31:0] pc);
    logic [15:0] h;
    h = mem16(pc);
    return (h[1:0] != 2'b11) ? 2 : 4;
  endfunction

  function automatic logic [31:0] iword(input logic [31:0] pc);
    logic [15:0] h0, h1;
    h0 = mem16(pc);
    if (h0[1:0] != 2'b11) return {16'h0000, h0};
    h1 = mem16(pc + 32'd2);
    return {h1, h0};
  endfunction

  // One cycle on instance A: drive, sample outputs, form expectations, advance model.
  task automatic tick(input logic redir, input logic [31:0] rpc, input logic ack_en, input logic rdy);
    logic [31:0] held;
    @(negedge clk);
    a_redirect = redir; a_redirect_pc = rpc; a_ready = rdy;
    #1;
    obs_cyc = a_cyc; obs_addr = a_addr;
    a_ack = ack_en;
    a_data = a_cyc ? mem_word(a_addr) : $urandom;
    #1;
    obs_valid = a_valid; obs_pc = a_pc; obs_instr = a_instr; obs_comp = a_comp;
    obs_level = {29'b0, a_level};
    held    = (m_fetch - {m_pc[31:2], 2'b00}) >> 2;
    e_level = held;
    e_cyc   = !redir && !m_fresh && (held < DEPTH);
    e_addr  = m_fetch;
    e_valid = (held * 4) >= ({30'b0, m_pc[1:0]} + ilen(m_pc));
    e_pc    = m_pc;
    e_instr = iword(m_pc);
    e_comp  = (ilen(m_pc) == 2);
    if (redir) begin
      m_pc    = rpc & ~32'h1;
      m_fetch = rpc & ~32'h3;
    end else begin
      if (e_cyc && ack_en) m_fetch = m_fetch + 32'd4;
      if (e_valid && rdy) m_pc = m_pc + ilen(m_pc);
    end
    m_fresh = 1'b0;
  endtask

  task automatic release_a();
    @(posedge clk);
    #1;
    a_reset_n = 1'b1; a_ack = 1'b0; a_redirect = 1'b0; a_ready = 1'b0;
    m_pc = 32'h0; m_fetch = 32'h0; m_fresh = 1'b1;
  endtask

  task automatic test_reset();
    a_reset_n = 1'b0; a_ack = 1'b1; a_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (a_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", a_cyc); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    checks++; if (a_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", a_level); end
    checks++; if (a_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", a_pc); end
    checks++; if (a_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", a_addr); end
    release_a();
  endtask

  task automatic test_fill();
    int nreq = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (obs_cyc !== e_cyc) begin errors++; $display("FAIL fill_cyc: cycle %0d got %b expected %b", i, obs_cyc, e_cyc); end
      checks++; if (obs_level !== e_level) begin errors++; $display("FAIL fill_level: cycle %0d got %0d expected %0d", i, obs_level, e_level); end
      if (obs_cyc) begin
        checks++; if (obs_addr !== 32'(nreq * 4)) begin errors++; $display("FAIL fill_addr: got %h expected %h", obs_addr, 32'(nreq * 4)); end
        nreq++;
      end
    end
    checks++; if (nreq !== 4) begin errors++; $display("FAIL fill_requests: got %0d expected 4", nreq); end
    checks++; if (obs_level !== 32'd4) begin errors++; $display("FAIL fill_full_level: got %0d expected 4", obs_level); end
    checks++; if (obs_cyc !== 1'b0) begin errors++; $display("FAIL fill_full_cyc: got %b expected 0", obs_cyc); end
  endtask

  task automatic test_decode();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    logic        cmp [3];
    logic [31:0] exp_pc [3]  = '{32'h0, 32'h4, 32'h6};
    logic [31:0] exp_in [3]  = '{32'h0000_0013, 32'h0000_0505, 32'h0000_4501};
    logic        exp_c [3]   = '{1'b0, 1'b1, 1'b1};
    int nacc = 0;
    for (int i = 0; i < 20 && nacc < 3; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_valid) begin
        pcs[nacc] = obs_pc; ins[nacc] = obs_instr; cmp[nacc] = obs_comp;
        nacc++;
      end
    end
    checks++; if (nacc !== 3) begin errors++; $display("FAIL decode_count: got %0d expected 3", nacc); end
    for (int k = 0; k < nacc; k++) begin
      checks++; if (pcs[k] !== exp_pc[k]) begin errors++; $display("FAIL decode_pc%0d: got %h expected %h", k, pcs[k], exp_pc[k]); end
      checks++; if (ins[k] !== exp_in[k]) begin errors++; $display("FAIL decode_instr%0d: got %h expected %h", k, ins[k], exp_in[k]); end
      checks++; if (cmp[k] !== exp_c[k]) begin errors++; $display("FAIL decode_comp%0d: got %b expected %b", k, cmp[k], exp_c[k]); end
    end
  endtask

  task automatic test_latency();
    tick(1'b1, 32'h100, 1'b0, 1'b0);
    checks++; if (obs_cyc !== 1'b0) begin errors++; $display("FAIL lat_redirect_cyc: got %b expected 0", obs_cyc); end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (obs_cyc !== 1'b1 || obs_addr !== 32'h100) begin errors++; $display("FAIL lat_req: got cyc=%b addr=%h expected cyc=1 addr=00000100", obs_cyc, obs_addr); end
    checks++; if (obs_valid !== 1'b0 || obs_level !== 32'd0) begin errors++; $display("FAIL lat_empty: got valid=%b level=%0d expected 0/0", obs_valid, obs_level); end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h100) begin errors++; $display("FAIL lat_valid: got valid=%b pc=%h expected 1/00000100", obs_valid, obs_pc); end
    checks++; if (obs_instr !== 32'h1 || obs_comp !== 1'b1) begin errors++; $display("FAIL lat_instr: got %h c=%b expected 00000001 c=1", obs_instr, obs_comp); end
  endtask

  task automatic test_split();
    tick(1'b1, 32'h102, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (obs_addr !== 32'h100 || obs_valid !== 1'b0) begin errors++; $display("FAIL split_w0: got addr=%h valid=%b expected 00000100/0", obs_addr, obs_valid); end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (obs_addr !== 32'h104 || obs_valid !== 1'b0) begin errors++; $display("FAIL split_w1: got addr=%h valid=%b expected 00000104/0", obs_addr, obs_valid); end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h102) begin errors++; $display("FAIL split_valid: got valid=%b pc=%h expected 1/00000102", obs_valid, obs_pc); end
    checks++; if (obs_instr !== 32'h0113_0093 || obs_comp !== 1'b0) begin errors++; $display("FAIL split_instr: got %h c=%b expected 01130093 c=0", obs_instr, obs_comp); end
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (obs_pc !== 32'h106 || obs_level !== 32'd1) begin errors++; $display("FAIL split_after: got pc=%h level=%0d expected 00000106/1", obs_pc, obs_level); end
  endtask

  task automatic test_abandon();
    tick(1'b1, 32'h10, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (obs_cyc !== 1'b1 || obs_addr !== 32'h10) begin errors++; $display("FAIL abandon_pending: got cyc=%b addr=%h expected 1/00000010", obs_cyc, obs_addr); end
    tick(1'b1, 32'h200, 1'b1, 1'b0);
    checks++; if (obs_cyc !== 1'b0) begin errors++; $display("FAIL abandon_cyc: got %b expected 0", obs_cyc); end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (obs_cyc !== 1'b1 || obs_addr !== 32'h200) begin errors++; $display("FAIL abandon_req: got cyc=%b addr=%h expected 1/00000200", obs_cyc, obs_addr); end
    checks++; if (obs_level !== 32'd0 || obs_valid !== 1'b0) begin errors++; $display("FAIL abandon_level: got level=%0d valid=%b expected 0/0", obs_level, obs_valid); end
  endtask

  task automatic test_random();
    logic        redir, ackr, rdy;
    logic [31:0] rpc;
    for (int i = 0; i < 400; i++) begin
      redir = ($urandom_range(0, 99) < 3);
      rpc   = $urandom & 32'h0000_FFFF;
      ackr  = ($urandom_range(0, 99) < 60);
      rdy   = ($urandom_range(0, 99) < 50);
      tick(redir, rpc, ackr, rdy);
      checks++; if (obs_cyc !== e_cyc) begin errors++; $display("FAIL rand_cyc: cycle %0d got %b expected %b", i, obs_cyc, e_cyc); end
      checks++; if (obs_level !== e_level) begin errors++; $display("FAIL rand_level: cycle %0d got %0d expected %0d", i, obs_level, e_level); end
      checks++; if (obs_valid !== e_valid) begin errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", i, obs_valid, e_valid); end
      if (e_cyc) begin
        checks++; if (obs_addr !== e_addr) begin errors++; $display("FAIL rand_addr: cycle %0d got %h expected %h", i, obs_addr, e_addr); end
      end
      if (e_valid) begin
        checks++; if (obs_pc !== e_pc) begin errors++; $display("FAIL rand_pc: cycle %0d got %h expected %h", i, obs_pc, e_pc); end
        checks++; if (obs_instr !== e_instr || obs_comp !== e_comp) begin errors++; $display("FAIL rand_instr: cycle %0d got %h c=%b expected %h c=%b", i, obs_instr, obs_comp, e_instr, e_comp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 32'h300, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    a_reset_n = 1'b0; a_ack = 1'b1; a_data = $urandom; a_ready = 1'b1;
    @(negedge clk);
    a_ack = 1'b0;
    #1;
    checks++; if (a_cyc !== 1'b0 || a_valid !== 1'b0 || a_level !== 3'd0) begin errors++; $display("FAIL midreset_outputs: got cyc=%b valid=%b level=%0d expected 0/0/0", a_cyc, a_valid, a_level); end
    release_a();
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (obs_cyc !== 1'b0) begin errors++; $display("FAIL midreset_first_cyc: got %b expected 0", obs_cyc); end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (obs_cyc !== 1'b1 || obs_addr !== 32'h0 || obs_level !== 32'd0) begin errors++; $display("FAIL midreset_req: got cyc=%b addr=%h level=%0d expected 1/00000000/0", obs_cyc, obs_addr, obs_level); end
  endtask

  task automatic test_wrap();
    logic [31:0] seen [2];
    int nreq = 0;
    @(negedge clk);
    #1;
    checks++; if (b_pc !== 32'hFFFF_FFFC || b_addr !== 32'hFFFF_FFFC || b_cyc !== 1'b0) begin errors++; $display("FAIL wrap_reset: got pc=%h addr=%h cyc=%b expected fffffffc/fffffffc/0", b_pc, b_addr, b_cyc); end
    @(posedge clk);
    #1;
    b_reset_n = 1'b1; b_ack = 1'b1; b_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      b_data = mem_word(b_addr);
      if (b_cyc && nreq < 2) begin seen[nreq] = b_addr; nreq++; end
    end
    checks++; if (nreq !== 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", nreq); end
    checks++; if (seen[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", seen[0]); end
    checks++; if (seen[1] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr1: got %h expected 00000000", seen[1]); end
  endtask

  task automatic test_ext_c0();
    logic [31:0] epc = 32'h104;
    int nacc = 0;
    @(negedge clk);
    b_redirect = 1'b1; b_redirect_pc = 32'h106; b_ready = 1'b0;
    #1;
    checks++; if (b_cyc !== 1'b0) begin errors++; $display("FAIL c0_redirect_cyc: got %b expected 0", b_cyc); end
    @(negedge clk);
    b_redirect = 1'b0;
    #1;
    b_data = mem_word(b_addr);
    checks++; if (b_cyc !== 1'b1 || b_addr !== 32'h104 || b_pc !== 32'h104) begin errors++; $display("FAIL c0_redirect: got cyc=%b addr=%h pc=%h expected 1/00000104/00000104", b_cyc, b_addr, b_pc); end
    b_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      b_data = mem_word(b_addr);
      #1;
      if (b_valid) begin
        checks++; if (b_pc !== epc) begin errors++; $display("FAIL c0_pc: got %h expected %h", b_pc, epc); end
        checks++; if (b_instr !== mem_word(epc) || b_comp !== 1'b0) begin errors++; $display("FAIL c0_instr: got %h c=%b expected %h c=0", b_instr, b_comp, mem_word(epc)); end
        epc = epc + 32'd4;
        nacc++;
      end
    end
    checks++; if (nacc < 8) begin errors++; $display("FAIL c0_count: got %0d expected at least 8", nacc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seed = $urandom;
    img[32'h0]   = 32'h0000_0013;
    img[32'h4]   = 32'h4501_0505;
    img[32'h100] = 32'h0093_0001;
    img[32'h104] = 32'h0000_0113;
    a_reset_n = 1'b0; a_redirect = 1'b0; a_redirect_pc = 32'h0; a_ack = 1'b0; a_data = 32'h0; a_ready = 1'b0;
    b_reset_n = 1'b0; b_redirect = 1'b0; b_redirect_pc = 32'h0; b_ack = 1'b0; b_data = 32'h0; b_ready = 1'b0;
    m_pc = 32'h0; m_fetch = 32'h0; m_fresh = 1'b1;
    test_reset();
    test_fill();
    test_decode();
    test_latency();
    test_split();
    test_abandon();
    test_random();
    test_reset_mid();
    test_wrap();
    test_ext_c0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_fetch_queue.md
RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, queue capacity in 32-bit words; power of two, >=2.
REQ-003 Parameter EXT_C, default 1; 1 = compressed (16-bit) instructions aligned on halfword boundaries, 0 = 32-bit only.
REQ-004 i_clk  in  1  clock; all state updates on rising edge.
REQ-005 i_reset_n  in  1  synchronous, active-low reset.
REQ-006 i_redirect  in  1  flush the queue and restart fetch at i_redirect_pc.
REQ-007 i_redirect_pc  in  32  new fetch PC; bit0 ignored; bit1 ignored when EXT_C=0.
REQ-008 o_cyc  out  1  bus request active.
REQ-009 o_addr  out  32  word-aligned fetch address; o_addr[1:0]=0.
REQ-010 i_ack  in  1  request complete; i_data valid this cycle.
REQ-011 i_data  in  32  fetched word.
REQ-012 o_valid  out  1  instruction available to decode.
REQ-013 o_pc  out  32  address of the presented instruction.
REQ-014 o_instr  out  32  instruction; compressed forms zero-extended from 16 bits.
REQ-015 o_compressed  out  1  presented instruction is 16-bit.
REQ-016 i_ready  in  1  decode accepts the instruction when o_valid & i_ready.
REQ-017 o_level  out  $clog2(DEPTH)+1  count of words held in the queue.

Function
REQ-018 Exactly one outstanding request; o_cyc and o_addr are registered and held stable until the cycle i_ack=1.
REQ-019 o_cyc=1 when out of reset, no redirect this cycle, and the request cannot overflow (level < DEPTH, with the in-flight word counted).
REQ-020 i_ack is ignored while o_cyc=0.
REQ-021 i_ack with o_cyc=1 and no redirect writes i_data at the queue tail; the fetch address advances by 4.
REQ-022 The fetch address wraps modulo 2^32 without error.
REQ-023 Push and pop in the same cycle are both honoured; level changes by net amount.
REQ-024 Head decode with EXT_C=1: halfword at offset = o_pc[1]; low bits != 2'b11 means compressed.
REQ-025 A compressed instruction is valid when level>=1.
REQ-026 A 32-bit instruction at offset 0 is valid when level>=1.
REQ-027 A 32-bit instruction at offset 1 spans head[31:16] and next[15:0] and is valid only when level>=2.
REQ-028 With EXT_C=0, every head word is one instruction and o_compressed=0.
REQ-029 On accept, o_pc advances by 2 (compressed) or 4.
REQ-030 On accept, a word is popped when the consumed instruction ends at or past the word's upper half; a 32-bit instruction at offset 1 pops one word and leaves offset 1.
REQ-031 While o_valid=1 and i_ready=0, o_pc, o_instr and o_compressed hold stable.
REQ-032 On i_redirect, the queue empties next cycle, and o_valid=0 that next cycle.
REQ-033 On i_redirect, o_pc loads i_redirect_pc with bit0 cleared (EXT_C=1) or [1:0] cleared (EXT_C=0).
REQ-034 On i_redirect, the fetch address loads i_redirect_pc & ~3.
REQ-035 On i_redirect, o_cyc=0 in the redirect cycle; an in-flight request is abandoned and a same-cycle i_ack is discarded.
REQ-036 Redirect has priority over a same-cycle accept and push; no queue state from that cycle survives.
REQ-037 Latency: redirect at N -> o_cyc=1 with new o_addr at N+1; ack at N+1 -> o_valid=1 at N+2.

Reset
REQ-038 While i_reset_n=0: o_cyc=0, o_valid=0, o_level=0.
REQ-039 While i_reset_n=0: fetch address=RESET_ADDR & ~3; o_pc=RESET_ADDR with bit0 cleared.
REQ-040 Reset asserted mid-request abandons the request and discards any ack; first o_cyc=1 is the cycle after reset release.

Verification
REQ-041 Reset release, i_ack every cycle, i_ready=0 -> o_addr 0,4,8,12, then o_cyc=0 with o_level=4 (DEPTH=4), and no fifth request.
REQ-042 Words 0x00000013, 0x4501_0505 at 0 and 4, i_ready=1 -> 32-bit at pc 0, then compressed 0x0505 at pc 4, then compressed 0x4501 at pc 6.
REQ-043 Redirect to 0x102 with word 0x0093_0001 at 0x100 and 0x0000_0113 at 0x104 -> o_pc=0x102 and o_instr=0x0113_0093, asserted only after both words have been acked.
REQ-044 Redirect to 0x200 while a request to 0x10 is pending, with i_ack in the same cycle -> data discarded, next o_addr=0x200, o_level=0.
REQ-045 RESET_ADDR=0xFFFF_FFFC, acks continuous -> o_addr 0xFFFF_FFFC then 0x0000_0000.
REQ-046 EXT_C=0, redirect to 0x106 -> o_addr=0x104, o_pc=0x104, o_compressed=0 for all instructions.
